// File: rtl/temp_sense_osc_counter.sv
// Multi-channel ring-oscillator edge counter for temperature sensing.
// Channels are enabled one at a time, settled, and counted over a 2^n CLK_REF window.
module temp_sense_osc_counter #(
  parameter int NCH        = 2,
  parameter int CNT_W      = 16,
  parameter int SEL_W      = 3,
  parameter int MIN_LOG2   = 6,
  parameter int SETTLE_CYC = 8
) (
  input  logic                 CLK_REF,
  input  logic                 RESET_COUNTERn,
  input  logic                 en,
  input  logic                 start,
  input  logic                 cont,
  input  logic [SEL_W-1:0]     sel_conv_time,
  input  logic [NCH-1:0]       osc_out,
  output logic [NCH-1:0]       osc_en,
  output logic [NCH*CNT_W-1:0] dout,
  output logic [NCH-1:0]       ovf,
  output logic                 busy,
  output logic                 done
);

  // state  | meaning
  // IDLE   | oscillators off, waiting for en & start
  // SETTLE | selected oscillator running, edges ignored
  // COUNT  | counting synchronized rising edges for the window
  // STORE  | write count/sat to the channel slice, advance or finish

  localparam int CH_W         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WIN_LOG2_MAX = (1 << SEL_W) - 1 + MIN_LOG2;
  localparam int TMR_W        = (WIN_LOG2_MAX > $clog2(SETTLE_CYC)) ?
                                WIN_LOG2_MAX : $clog2(SETTLE_CYC) + 1;

  localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_STORE} state_t;

  state_t             state_q;
  logic [CH_W-1:0]    ch_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [SEL_W-1:0]   sel_q;
  logic               cont_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;
  logic [NCH-1:0]     osc_en_q;
  logic [NCH*CNT_W-1:0] dout_q;
  logic [NCH-1:0]     ovf_q;
  logic               busy_q;
  logic               done_q;
  logic [NCH-1:0]     osc_s1_q, osc_s2_q, osc_s3_q;
  logic               edge_sel;

  // Window length minus one; at the largest select the shift wraps to zero, giving all-ones.
  function automatic logic [TMR_W-1:0] win_m1(input logic [SEL_W-1:0] s);
    logic [TMR_W-1:0] one;
    one = TMR_W'(1);
    return (one << (int'(s) + MIN_LOG2)) - one;
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++)
      if (c == CH_W'(i)) r[i] = 1'b1;
    return r;
  endfunction

  always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
    if (!RESET_COUNTERn) begin
      osc_s1_q <= '0;
      osc_s2_q <= '0;
      osc_s3_q <= '0;
    end else begin
      osc_s1_q <= osc_out;
      osc_s2_q <= osc_s1_q;
      osc_s3_q <= osc_s2_q;
    end
  end

  always_comb begin
    edge_sel = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (ch_q == CH_W'(i)) edge_sel = osc_s2_q[i] & ~osc_s3_q[i];
  end

  always_ff @(posedge CLK_REF or negedge RESET_COUNTERn) begin
    if (!RESET_COUNTERn) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      tmr_q    <= '0;
      sel_q    <= '0;
      cont_q   <= 1'b0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      osc_en_q <= '0;
      dout_q   <= '0;
      ovf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en && start) begin
            sel_q    <= sel_conv_time;
            cont_q   <= cont;
            ch_q     <= '0;
            tmr_q    <= SETTLE_M1;
            cnt_q    <= '0;
            sat_q    <= 1'b0;
            osc_en_q <= onehot('0);
            busy_q   <= 1'b1;
            state_q  <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!en) begin
            osc_en_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else if (tmr_q == '0) begin
            tmr_q   <= win_m1(sel_q);
            state_q <= S_COUNT;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_COUNT: begin
          if (!en) begin
            osc_en_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            if (edge_sel) begin
              if (cnt_q == CNT_MAX) sat_q <= 1'b1;
              else                  cnt_q <= cnt_q + 1'b1;
            end
            if (tmr_q == '0) begin
              done_q  <= (ch_q == CH_LAST);
              state_q <= S_STORE;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
        end
        S_STORE: begin
          // The slice is written even if en drops in this very cycle.
          for (int i = 0; i < NCH; i++) begin
            if (ch_q == CH_W'(i)) begin
              dout_q[i*CNT_W +: CNT_W] <= cnt_q;
              ovf_q[i]                 <= sat_q;
            end
          end
          cnt_q <= '0;
          sat_q <= 1'b0;
          tmr_q <= SETTLE_M1;
          if (en && ch_q != CH_LAST) begin
            ch_q     <= ch_q + 1'b1;
            osc_en_q <= onehot(ch_q + 1'b1);
            state_q  <= S_SETTLE;
          end else if (en && cont && cont_q && ch_q == CH_LAST) begin
            ch_q     <= '0;
            sel_q    <= sel_conv_time;
            osc_en_q <= onehot('0);
            state_q  <= S_SETTLE;
          end else begin
            osc_en_q <= '0;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        default: begin
          osc_en_q <= '0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign osc_en = osc_en_q;
  assign dout   = dout_q;
  assign ovf    = ovf_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule
